universal_shift_reg: RTL and testbench

//   Parametrised successor to the 4-bit serial-in/serial-out shift register.
//   - Adds bidirectional shift, parallel load, parallel readout and a counted burst-shift engine.
//   - Used as the generic serialiser/deserialiser stage of the datapath.
//   - Single clock domain.

---
 rtl/shift_reg_pkg.sv | 13 +
 rtl/shift_burst_ctrl.sv | 133 +++++++++++++
 rtl/universal_shift_reg.sv | 105 ++++++++++
 tb/tb_universal_shift_reg.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/shift_reg_pkg.sv
// Shared types and constants for the universal shift register.
// Optional feature macro: USR_ROTATE_EN (adds circular-rotate fill).
package shift_reg_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_e;

  localparam logic DIR_LEFT  = 1'b0;
  localparam logic DIR_RIGHT = 1'b1;

endpackage

// File: rtl/shift_burst_ctrl.sv
// Burst controller: IDLE/BURST FSM and shift counter for universal_shift_reg.
// Decides per edge whether the datapath loads, shifts, and in which direction.
// Optional feature macro: USR_ROTATE_EN (latches the rotate request for a burst).
module shift_burst_ctrl
  import shift_reg_pkg::*;
#(
  parameter  int WIDTH = 4,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             load,
  input  logic             start,
  input  logic             step,
  input  logic [CNT_W-1:0] shamt,
  input  logic             dir,
`ifdef USR_ROTATE_EN
  input  logic             rotate,
  output logic             rot_eff,
`endif
  output logic             load_en,
  output logic             shift_en,
  output logic             dir_eff,
  output logic             busy,
  output logic             done
);

  localparam logic [CNT_W-1:0] WIDTH_C = CNT_W'(WIDTH);
  localparam logic [CNT_W-1:0] ONE_C   = CNT_W'(1);
  localparam logic [CNT_W-1:0] ZERO_C  = CNT_W'(0);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             dir_lat_q, dir_lat_d;
  logic             done_q, done_d;
  logic [CNT_W-1:0] n_s;
`ifdef USR_ROTATE_EN
  logic             rot_lat_q, rot_lat_d;
`endif

  // Clamp requested burst length to the register width.
  always_comb begin
    n_s = shamt;
    if (shamt > WIDTH_C) begin
      n_s = WIDTH_C;
    end else begin
      n_s = shamt;
    end
  end

  // Next-state, counter and per-edge datapath controls.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    dir_lat_d = dir_lat_q;
    done_d    = 1'b0;
    load_en   = 1'b0;
    shift_en  = 1'b0;
    dir_eff   = dir;
`ifdef USR_ROTATE_EN
    rot_lat_d = rot_lat_q;
    rot_eff   = rotate;
`endif
    case (state_q)
      IDLE: begin
        dir_eff = dir;
        if (load) begin
          load_en = 1'b1;
        end else if (start) begin
          if (n_s != ZERO_C) begin
            state_d   = BURST;
            cnt_d     = n_s;
            dir_lat_d = dir;
`ifdef USR_ROTATE_EN
            rot_lat_d = rotate;
`endif
          end else begin
            // Zero-length burst completes immediately.
            done_d = 1'b1;
          end
        end else if (step) begin
          shift_en = 1'b1;
        end else begin
          shift_en = 1'b0;
        end
      end
      BURST: begin
        // Direction (and rotate mode) are frozen for the whole burst.
        dir_eff  = dir_lat_q;
`ifdef USR_ROTATE_EN
        rot_eff  = rot_lat_q;
`endif
        shift_en = 1'b1;
        cnt_d    = cnt_q - ONE_C;
        if (cnt_q == ONE_C) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          state_d = BURST;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = ZERO_C;
      end
    endcase
  end

  // Control state registers with asynchronous reset.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state_q   <= IDLE;
      cnt_q     <= ZERO_C;
      dir_lat_q <= DIR_LEFT;
      done_q    <= 1'b0;
`ifdef USR_ROTATE_EN
      rot_lat_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      dir_lat_q <= dir_lat_d;
      done_q    <= done_d;
`ifdef USR_ROTATE_EN
      rot_lat_q <= rot_lat_d;
`endif
    end
  end

  assign busy = (state_q == BURST);
  assign done = done_q;

endmodule

// File: rtl/universal_shift_reg.sv
// Universal shift register: bidirectional shift, parallel load/readout and a
// counted burst-shift engine. Used as a generic serialiser/deserialiser stage.
// Optional feature macro: USR_ROTATE_EN (adds 'rotate' input for circular fill).
module universal_shift_reg
  import shift_reg_pkg::*;
#(
  parameter  int WIDTH = 4,
  localparam int CNT_W = $clog2(WIDTH + 1)
) (
  input  logic             CLK,
  input  logic             Reset,
  input  logic             load,
  input  logic [WIDTH-1:0] par_in,
  input  logic             dir,
  input  logic             Shift_in,
  input  logic             step,
  input  logic             start,
  input  logic [CNT_W-1:0] shamt,
`ifdef USR_ROTATE_EN
  input  logic             rotate,
`endif
  output logic [WIDTH-1:0] q,
  output logic             shift_out,
  output logic             busy,
  output logic             done
);

  logic [WIDTH-1:0] q_q, q_d;
  logic             load_en_s;
  logic             shift_en_s;
  logic             dir_eff_s;
  logic             out_bit_s;
  logic             fill_s;
`ifdef USR_ROTATE_EN
  logic             rot_eff_s;
`endif

  shift_burst_ctrl #(
    .WIDTH (WIDTH)
  ) u_ctrl (
    .CLK      (CLK),
    .Reset    (Reset),
    .load     (load),
    .start    (start),
    .step     (step),
    .shamt    (shamt),
    .dir      (dir),
`ifdef USR_ROTATE_EN
    .rotate   (rotate),
    .rot_eff  (rot_eff_s),
`endif
    .load_en  (load_en_s),
    .shift_en (shift_en_s),
    .dir_eff  (dir_eff_s),
    .busy     (busy),
    .done     (done)
  );

  // Select the outgoing bit and the fill bit for the next shift.
  always_comb begin
    if (dir_eff_s == DIR_RIGHT) begin
      out_bit_s = q_q[0];
    end else begin
      out_bit_s = q_q[WIDTH-1];
    end
`ifdef USR_ROTATE_EN
    if (rot_eff_s) begin
      fill_s = out_bit_s;
    end else begin
      fill_s = Shift_in;
    end
`else
    fill_s = Shift_in;
`endif
  end

  // Datapath next value: parallel load has priority over shifting.
  always_comb begin
    q_d = q_q;
    if (load_en_s) begin
      q_d = par_in;
    end else if (shift_en_s) begin
      if (dir_eff_s == DIR_LEFT) begin
        q_d = {q_q[WIDTH-2:0], fill_s};
      end else begin
        q_d = {fill_s, q_q[WIDTH-1:1]};
      end
    end else begin
      q_d = q_q;
    end
  end

  // Datapath register with asynchronous reset.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q         = q_q;
  assign shift_out = out_bit_s;

endmodule

// File: tb/tb_universal_shift_reg.sv
// Self-checking bench for universal_shift_reg (WIDTH=4): directed vector table,
// hand-written corner sequences and randomized stimulus against a reference model.
module tb_universal_shift_reg;

  localparam int W  = 4;
  localparam int CW = $clog2(W + 1);

  logic          CLK;
  logic          Reset;
  logic          load;
  logic [W-1:0]  par_in;
  logic          dir;
  logic          Shift_in;
  logic          step;
  logic          start;
  logic [CW-1:0] shamt;
  logic          rotate;
  logic [W-1:0]  q;
  logic          shift_out;
  logic          busy;
  logic          done;

  int errors = 0;
  int checks = 0;

  universal_shift_reg #(.WIDTH(W)) dut (
    .CLK       (CLK),
    .Reset     (Reset),
    .load      (load),
    .par_in    (par_in),
    .dir       (dir),
    .Shift_in  (Shift_in),
    .step      (step),
    .start     (start),
    .shamt     (shamt),
`ifdef USR_ROTATE_EN
    .rotate    (rotate),
`endif
    .q         (q),
    .shift_out (shift_out),
    .busy      (busy),
    .done      (done)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic          ld;
    logic [W-1:0]  pin;
    logic          dr;
    logic          sin;
    logic          stp;
    logic          sta;
    logic [CW-1:0] sa;
    logic [W-1:0]  eq;
    logic          ebusy;
    logic          edone;
  } vec_t;

  vec_t vecs[$];

  // Reference model state
  int  m_q;
  bit  m_busy;
  int  m_left;
  bit  m_dir;
  bit  m_rot;
  bit  m_done;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    load = 1'b0; par_in = '0; dir = 1'b0; Shift_in = 1'b0;
    step = 1'b0; start = 1'b0; shamt = '0; rotate = 1'b0;
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // One shift of an integer-valued register, computed arithmetically.
  function automatic int shifted(input int v, input bit right, input bit sin, input bit rot);
    int outb;
    int fill;
    outb = right ? (v & 1) : ((v >> (W - 1)) & 1);
    fill = rot ? outb : int'(sin);
    if (right) return (v >> 1) | (fill << (W - 1));
    else       return ((v << 1) | fill) & ((1 << W) - 1);
  endfunction

  // Advance the model by one clock edge using the currently driven inputs.
  task automatic model_edge();
    int n;
    bit rot_now;
`ifdef USR_ROTATE_EN
    rot_now = rotate;
`else
    rot_now = 1'b0;
`endif
    if (Reset) begin
      m_q = 0; m_busy = 0; m_left = 0; m_dir = 0; m_rot = 0; m_done = 0;
    end else begin
      m_done = 0;
      if (!m_busy) begin
        if (load) m_q = int'(par_in);
        else if (start) begin
          n = (int'(shamt) > W) ? W : int'(shamt);
          if (n > 0) begin
            m_busy = 1; m_left = n; m_dir = dir; m_rot = rot_now;
          end else m_done = 1;
        end else if (step) m_q = shifted(m_q, dir, Shift_in, rot_now);
      end else begin
        m_q = shifted(m_q, m_dir, Shift_in, m_rot);
        m_left--;
        if (m_left == 0) begin
          m_busy = 0; m_done = 1;
        end
      end
    end
  endtask

  function automatic int model_so();
    bit d;
    d = m_busy ? m_dir : dir;
    return d ? (m_q & 1) : ((m_q >> (W - 1)) & 1);
  endfunction

  initial begin
    idle_inputs();
    Reset = 1'b1;
    #3;
    check("reset_q", int'(q), 0);
    check("reset_busy", int'(busy), 0);
    check("reset_done", int'(done), 0);
    tick();
    Reset = 1'b0;

    // Test 1: load then single left step; shift_out sampled before the edge.
    load = 1'b1; par_in = 4'b1011;
    tick();
    idle_inputs();
    step = 1'b1; dir = 1'b0; Shift_in = 1'b0;
    #1;
    check("t1_shift_out_pre", int'(shift_out), 1);
    tick();
    check("t1_q_after_step", int'(q), 4'b0110);
    idle_inputs();

    // Directed vector table (expected values after each edge).
    vecs.push_back('{1'b1, 4'b1011, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 4'b1011, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b1, 3'd3, 4'b1011, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 4'b1101, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 4'b1110, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b0, 3'd0, 4'b1111, 1'b0, 1'b1});
    vecs.push_back('{1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 4'b1111, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0, 4'b1111, 1'b0, 1'b1});
    vecs.push_back('{1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 4'b1111, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 4'b0001, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 4'b0001, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b1, 3'd7, 4'b0001, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 4'b0010, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 4'b0100, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 4'b1000, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 4'b0000, 1'b0, 1'b1});
    vecs.push_back('{1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 4'b0000, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 4'b1011, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 4'b1011, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 4'b0000, 1'b1, 1'b0, 1'b0, 1'b1, 3'd2, 4'b1011, 1'b1, 1'b0});
    vecs.push_back('{1'b1, 4'b0000, 1'b0, 1'b0, 1'b1, 1'b1, 3'd3, 4'b0101, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 4'b0000, 1'b0, 1'b1, 1'b0, 1'b1, 3'd3, 4'b1010, 1'b0, 1'b1});
    vecs.push_back('{1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0, 4'b1010, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 4'b0000, 1'b1, 1'b0, 1'b1, 1'b0, 3'd0, 4'b0101, 1'b0, 1'b0});

    for (int i = 0; i < vecs.size(); i++) begin
      load = vecs[i].ld; par_in = vecs[i].pin; dir = vecs[i].dr;
      Shift_in = vecs[i].sin; step = vecs[i].stp; start = vecs[i].sta;
      shamt = vecs[i].sa;
      tick();
      check($sformatf("vec%0d_q", i), int'(q), int'(vecs[i].eq));
      check($sformatf("vec%0d_busy", i), int'(busy), int'(vecs[i].ebusy));
      check($sformatf("vec%0d_done", i), int'(done), int'(vecs[i].edone));
    end
    idle_inputs();

    // Test 5: asynchronous reset two cycles into a full-width burst.
    load = 1'b1; par_in = 4'b1111;
    tick();
    idle_inputs();
    start = 1'b1; shamt = 3'd4; dir = 1'b0; Shift_in = 1'b0;
    tick();
    idle_inputs();
    tick();
    tick();
    check("t5_busy_before_reset", int'(busy), 1);
    #2;
    Reset = 1'b1;
    #1;
    check("t5_async_q", int'(q), 0);
    check("t5_async_busy", int'(busy), 0);
    check("t5_async_done", int'(done), 0);
    tick();
    Reset = 1'b0;
    tick();
    check("t5_stays_idle", int'(busy), 0);

`ifdef USR_ROTATE_EN
    // Test 6: rotate step and full-width rotate burst.
    idle_inputs();
    load = 1'b1; par_in = 4'b1011;
    tick();
    idle_inputs();
    step = 1'b1; dir = 1'b0; rotate = 1'b1;
    tick();
    check("t6_rotate_step", int'(q), 4'b0111);
    idle_inputs();
    start = 1'b1; dir = 1'b1; shamt = 3'd4; rotate = 1'b1;
    tick();
    idle_inputs();
    Shift_in = 1'b1;
    for (int k = 0; k < 4; k++) tick();
    check("t6_rotate_burst_q", int'(q), 4'b0111);
    check("t6_rotate_burst_done", int'(done), 1);
`endif

    // Randomized stimulus against the reference model.
    idle_inputs();
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    m_q = 0; m_busy = 0; m_left = 0; m_dir = 0; m_rot = 0; m_done = 0;
    for (int c = 0; c < 400; c++) begin
      load     = ($urandom_range(0, 7) == 0);
      par_in   = W'($urandom);
      dir      = 1'($urandom);
      Shift_in = 1'($urandom);
      step     = 1'($urandom);
      start    = ($urandom_range(0, 3) == 0);
      shamt    = CW'($urandom);
      rotate   = 1'($urandom);
      Reset    = ($urandom_range(0, 63) == 0);
      #1;
      if (!Reset) check($sformatf("rnd%0d_shift_out", c), int'(shift_out), model_so());
      model_edge();
      tick();
      Reset = 1'b0;
      check($sformatf("rnd%0d_q", c), int'(q), m_q);
      check($sformatf("rnd%0d_busy", c), int'(busy), int'(m_busy));
      check($sformatf("rnd%0d_done", c), int'(done), int'(m_done));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
